// File: rtl/seq_ser_pkg.sv
// Shared types and constants for the bit serializer.
// Holds state encoding, idle-level default and counter sizing.
package seq_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  localparam logic IDLE_BIT_DEF = 1'b1;

  // GAP is limited to 0..15
  localparam int GAP_CW = 4;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_bit_serializer_gap.sv
// ser_gap_timer: loadable down-counter that times the GAP state.
// Ports: clk, rst (sync, high), load, expire (last gap cycle).
module ser_gap_timer
  import seq_ser_pkg::*;
#(
  parameter int GAP = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  logic [GAP_CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= GAP_CW'(GAP);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // loaded on GAP entry, so GAP,..,1 spans GAP cycles
  assign expire = (cnt == GAP_CW'(1));

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stage feeding the 000 detector, MSB first.
// Ports: clk, rst (sync, high), din/din_valid/din_ready handshake,
//   sout/sout_valid serial line, busy, word_done (last-bit pulse).
// Option: define SER_PARITY_EN to append an even-parity bit.
module seq_bit_serializer
  import seq_ser_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   GAP      = 0,
  parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = cnt_width(WIDTH);
`ifdef SER_PARITY_EN
  localparam int LEN = WIDTH + 1;
`else
  localparam int LEN = WIDTH;
`endif

  state_t           state;
  state_t           nstate;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             take;
  logic             gap_load;
  logic             gap_expire;
  logic             data_bit;

  assign last = (state == ST_SHIFT) && (cnt == CW'(LEN - 1));

  // back-to-back window only exists without a gap
  assign din_ready = !rst &&
    ((state == ST_IDLE) || ((GAP == 0) && last));

  assign take = din_valid && din_ready;

`ifdef SER_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (take) begin
      par <= ^din;
    end
  end

  // the parity slot follows bit 0
  assign data_bit = (cnt == CW'(WIDTH)) ? par : shreg[WIDTH-1];
`else
  assign data_bit = shreg[WIDTH-1];
`endif

  always_comb begin
    nstate   = state;
    gap_load = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (take) nstate = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last) begin
          if (take) begin
            nstate = ST_SHIFT;
          end else if (GAP == 0) begin
            nstate = ST_IDLE;
          end else begin
            nstate   = ST_GAP;
            gap_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_expire) nstate = ST_IDLE;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  ser_gap_timer #(
    .GAP (GAP)
  ) u_gap (
    .clk    (clk),
    .rst    (rst),
    .load   (gap_load),
    .expire (gap_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sout       <= IDLE_BIT;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state     <= nstate;
      busy      <= (nstate != ST_IDLE);
      word_done <= last;
      if (state == ST_SHIFT) begin
        sout       <= data_bit;
        sout_valid <= 1'b1;
      end else begin
        sout       <= IDLE_BIT;
        sout_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (take) begin
      shreg <= din;
      cnt   <= '0;
    end else if (last) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == ST_SHIFT) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: vector table, corner sequences,
// random traffic against a timeline model (GAP=0 and GAP=2 DUTs).
module tb_seq_bit_serializer;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif
  localparam int G2 = 2;
  localparam int RN = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         word_done;

  logic [W-1:0] din2;
  logic         v2;
  logic         rdy2;
  logic         sout2;
  logic         sv2;
  logic         busy2;
  logic         wd2;

  seq_bit_serializer #(.WIDTH(W), .GAP(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .word_done  (word_done)
  );

  seq_bit_serializer #(.WIDTH(W), .GAP(G2)) dut_g (
    .clk        (clk),
    .rst        (rst),
    .din        (din2),
    .din_valid  (v2),
    .din_ready  (rdy2),
    .sout       (sout2),
    .sout_valid (sv2),
    .busy       (busy2),
    .word_done  (wd2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] exp_bits;
    logic         exp_par;
    int           exp_det;
  } vec_t;

  vec_t tab[8];

  // send one word on the GAP=0 DUT; det counts detector pulses
  task automatic send_word(input logic [W-1:0] w,
                           output logic [L:1] bits,
                           output logic [L:1] wds,
                           output int det);
    int zrun;
    zrun = 0;
    det  = 0;
    din       = w;
    din_valid = 1'b1;
    chk("send_ready", din_ready, 1);
    tick();
    din_valid = 1'b0;
    chk("send_lat_sv", sout_valid, 0);
    chk("send_lat_sout", sout, 1);
    for (int k = 1; k <= L; k++) begin
      tick();
      bits[k] = sout;
      wds[k]  = word_done;
      chk("send_sv", sout_valid, 1);
      zrun = (sout == 1'b0) ? zrun + 1 : 0;
      if (zrun == 3) det++;
    end
    tick();
    chk("send_tail_sout", sout, 1);
    chk("send_tail_busy", busy, 0);
  endtask

  logic [L:1]     bits;
  logic [L:1]     wds;
  int             det;
  logic [2*L-1:0] b2b_exp;
  logic [L-1:0]   gw1;
  logic [L-1:0]   gw2;
  int             zeros;
  logic           es [2][0:399];
  logic           ev [2][0:399];
  logic           ew [2][0:399];
  int             next_ok [2];
  int             gaps [2];

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0;
    din2 = '0; v2 = 1'b0;

    tab[0] = '{8'hA5, 8'b1010_0101, 1'b0, 0};
    tab[1] = '{8'hF0, 8'b1111_0000, 1'b0, 1};
    tab[2] = '{8'h0F, 8'b0000_1111, 1'b0, 1};
    tab[3] = '{8'h00, 8'b0000_0000, 1'b0, 1};
    tab[4] = '{8'hFF, 8'b1111_1111, 1'b0, 0};
    tab[5] = '{8'h01, 8'b0000_0001, 1'b1, 1};
    tab[6] = '{8'h80, 8'b1000_0000, 1'b1, 1};
    tab[7] = '{8'hC7, 8'b1100_0111, 1'b1, 1};

    @(negedge clk);

    // reset with valid held: nothing may be accepted
    din = 8'h5A; din_valid = 1'b1; v2 = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_ready", din_ready, 0);
      chk("rst_ready_g", rdy2, 0);
      chk("rst_sout", sout, 1);
      chk("rst_sv", sout_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wd", word_done, 0);
    end
    rst = 1'b0; din_valid = 1'b0; v2 = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_sv", sout_valid, 0);
    chk("post_rst_ready", din_ready, 1);
    chk("post_rst_ready_g", rdy2, 1);

    // vector table, including detector integration on C7
    for (int i = 0; i < 8; i++) begin
      send_word(tab[i].din, bits, wds, det);
      for (int k = 1; k <= W; k++)
        chk($sformatf("tab%0d_bit%0d", i, k), bits[k],
            tab[i].exp_bits[W-k]);
`ifdef SER_PARITY_EN
      chk($sformatf("tab%0d_par", i), bits[L], tab[i].exp_par);
`endif
      for (int k = 1; k <= L; k++)
        chk($sformatf("tab%0d_wd%0d", i, k), wds[k], k == L);
      chk($sformatf("tab%0d_det", i), det, tab[i].exp_det);
    end

    // back-to-back on GAP=0
`ifdef SER_PARITY_EN
    b2b_exp = 18'b11110000_0_00001111_0;
`else
    b2b_exp = 16'b11110000_00001111;
`endif
    din = 8'hF0; din_valid = 1'b1;
    chk("b2b_ready0", din_ready, 1);
    tick();
    din = 8'h0F;
    for (int c = 0; c <= 2 * L; c++) begin
      chk($sformatf("b2b_ready_c%0d", c), din_ready,
          (c == L - 1) || (c >= 2 * L - 1));
      if (c >= 1) begin
        chk($sformatf("b2b_bit_c%0d", c), sout, b2b_exp[2*L-c]);
        chk("b2b_sv", sout_valid, 1);
        chk($sformatf("b2b_wd_c%0d", c), word_done,
            (c == L) || (c == 2 * L));
      end
      if (c < 2 * L) tick();
      if (c == L - 1) din_valid = 1'b0;
    end
    tick();
    chk("b2b_end_busy", busy, 0);
    chk("b2b_end_sout", sout, 1);

    // GAP=2: state GAP lasts 2 cycles, then one IDLE accept cycle
`ifdef SER_PARITY_EN
    gw1 = 9'b1001_0110_0;
    gw2 = 9'b0011_1100_0;
`else
    gw1 = 8'b1001_0110;
    gw2 = 8'b0011_1100;
`endif
    din2 = 8'h96; v2 = 1'b1;
    chk("gap_ready0", rdy2, 1);
    tick();
    din2 = 8'h3C;
    for (int c = 0; c <= 2 * L + 3; c++) begin
      chk($sformatf("gap_ready_c%0d", c), rdy2, c == L + G2);
      chk($sformatf("gap_busy_c%0d", c), busy2, c != L + G2);
      chk($sformatf("gap_wd_c%0d", c), wd2,
          (c == L) || (c == 2 * L + G2 + 1));
      if (c >= 1 && c <= L) begin
        chk($sformatf("gap_w1_c%0d", c), sout2, gw1[L-c]);
        chk("gap_w1_sv", sv2, 1);
      end else if (c > L && c <= L + G2 + 1) begin
        chk($sformatf("gap_idle_c%0d", c), sout2, 1);
        chk($sformatf("gap_idle_sv_c%0d", c), sv2, 0);
      end else if (c > L + G2 + 1) begin
        chk($sformatf("gap_w2_c%0d", c), sout2,
            gw2[2*L+G2+1-c]);
        chk("gap_w2_sv", sv2, 1);
      end
      if (c < 2 * L + 3) tick();
      if (c == L + G2) v2 = 1'b0;
    end
    repeat (G2 + 2) tick();
    chk("gap_end_busy", busy2, 0);
    chk("gap_end_ready", rdy2, 1);

    // reset during the 4th bit of an all-zero word
    din = 8'h00; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    zeros = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (sout == 1'b0) zeros++;
    end
    rst = 1'b1;
    tick();
    chk("midrst_sout", sout, 1);
    chk("midrst_sv", sout_valid, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (sout == 1'b0) zeros++;
      chk("midrst_after_sv", sout_valid, 0);
    end
    chk("midrst_zeros", zeros, 3);

    // random traffic against a per-edge timeline model
    gaps[0] = 0;
    gaps[1] = G2;
    for (int i = 0; i < 2; i++) begin
      next_ok[i] = 0;
      for (int e = 0; e < 400; e++) begin
        es[i][e] = 1'b1;
        ev[i][e] = 1'b0;
        ew[i][e] = 1'b0;
      end
    end
    for (int e = 0; e < RN; e++) begin
      for (int i = 0; i < 2; i++) begin
        logic         ao;
        logic         avv;
        logic         aw;
        logic         ar;
        logic         rexp;
        logic         v;
        logic [W-1:0] w;
        int           t;
        ao   = (i == 0) ? sout : sout2;
        avv  = (i == 0) ? sout_valid : sv2;
        aw   = (i == 0) ? word_done : wd2;
        ar   = (i == 0) ? din_ready : rdy2;
        rexp = (e + 1 >= next_ok[i]);
        chk($sformatf("rnd%0d_sout_e%0d", i, e), ao, es[i][e]);
        chk($sformatf("rnd%0d_sv_e%0d", i, e), avv, ev[i][e]);
        chk($sformatf("rnd%0d_wd_e%0d", i, e), aw, ew[i][e]);
        chk($sformatf("rnd%0d_ready_e%0d", i, e), ar, rexp);
        v = ($urandom_range(0, 99) < 60);
        w = W'($urandom);
        if (i == 0) begin
          din_valid = v;
          din       = w;
        end else begin
          v2   = v;
          din2 = w;
        end
        if (v && rexp) begin
          t = e + 1;
          for (int k = 1; k <= W; k++) begin
            es[i][t+k] = w[W-k];
            ev[i][t+k] = 1'b1;
          end
`ifdef SER_PARITY_EN
          es[i][t+L] = ^w;
          ev[i][t+L] = 1'b1;
`endif
          ew[i][t+L] = 1'b1;
          next_ok[i] = t + L + ((gaps[i] > 0) ? gaps[i] + 1 : 0);
        end
      end
      tick();
    end
    din_valid = 1'b0;
    v2 = 1'b0;
    repeat (L + G2 + 4) tick();
    chk("rnd_end_busy", busy, 0);
    chk("rnd_end_busy_g", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
